// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one count pulse-counter among N_REQ requesters
module count_sched #(
  parameter int N_REQ = 4,
  parameter int W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_pulsos,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           err,
  output logic                       cnt_iniciar,
  output logic [W-1:0]               cnt_pulsos,
  input  logic                       cnt_pronto,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, FINISH, ABORT, RELEASE} state_t;
  state_t state, nxt;
  logic [IW-1:0] job_id, last_grant, win, idx;
  logic [W-1:0] job_pulsos, win_pulsos;
  logic [15:0] tcnt;
  logic found, take;
  // search for the first valid requester after the last winner, wrapping around
  always_comb begin
    win = last_grant;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign win_pulsos = req_pulsos[int'(win)*W +: W];
  assign take = rst && state == IDLE && !cnt_pronto && found;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // job latch, arbitration pointer and timeout counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      job_id <= '0;
      job_pulsos <= '0;
      last_grant <= IW'(N_REQ - 1);
      tcnt <= '0;
    end else begin
      if (take) begin
        job_id <= win;
        job_pulsos <= win_pulsos;
        last_grant <= win;
      end
      if (state == LAUNCH) tcnt <= '0;
      else if (state == BUSY) tcnt <= tcnt + 16'd1;
    end
  // next state; a zero-pulse job never launched count so it skips the RELEASE wait
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = take ? (win_pulsos == '0 ? FINISH : LAUNCH) : IDLE;
      LAUNCH:  nxt = BUSY;
      BUSY:    nxt = cnt_pronto ? FINISH : (tcnt + 16'd1 == 16'(TIMEOUT)) ? ABORT : BUSY;
      FINISH:  nxt = (job_pulsos == '0 && !cnt_pronto) ? IDLE : RELEASE;
      ABORT:   nxt = RELEASE;
      RELEASE: nxt = cnt_pronto ? RELEASE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign req_ready = take ? N_REQ'(1) << win : '0;
  assign done = state == FINISH ? N_REQ'(1) << job_id : '0;
  assign err = state == ABORT ? N_REQ'(1) << job_id : '0;
  assign cnt_iniciar = state == LAUNCH;
  assign cnt_pulsos = state == IDLE ? '0 : job_pulsos;
  assign busy = state != IDLE;
  assign grant_id = job_id;
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: directed self-checking bench for count_sched
module tb_count_sched;
  logic clk = 0, rst = 0;
  logic [3:0] req_valid = '0;
  logic [15:0] req_pulsos = '0;
  logic [3:0] req_ready, done, err;
  logic cnt_iniciar, cnt_pronto = 0, busy;
  logic [3:0] cnt_pulsos;
  logic [1:0] grant_id;
  int checks = 0, errors = 0;
  logic [3:0] pv [4] = '{4'd2, 4'd3, 4'd1, 4'd4};

  count_sched #(.N_REQ(4), .W(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pulsos(req_pulsos),
    .req_ready(req_ready), .done(done), .err(err), .cnt_iniciar(cnt_iniciar),
    .cnt_pulsos(cnt_pulsos), .cnt_pronto(cnt_pronto), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ini", cnt_iniciar, 0);
    chk("rst_pulsos", cnt_pulsos, 0);
    chk("rst_gid", grant_id, 0);
    step();
    step();
    rst = 1;
    // single job on requester 1 with 3 pulses
    req_valid = 4'b0010;
    req_pulsos = 16'h0030;
    #1 chk("t1_ready", req_ready, 4'b0010);
    step();
    req_valid = 0;
    #1 chk("t1_ini", cnt_iniciar, 1);
    chk("t1_pulsos", cnt_pulsos, 3);
    chk("t1_gid", grant_id, 1);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_ini_off", cnt_iniciar, 0);
    step();
    cnt_pronto = 1;
    #1 chk("t1_nodone", done, 0);
    step();
    chk("t1_done", done, 4'b0010);
    chk("t1_hold", cnt_pulsos, 3);
    step();
    chk("t1_rel_done", done, 0);
    chk("t1_rel_busy", busy, 1);
    step();
    cnt_pronto = 0;
    #1 chk("t1_rel_wait", busy, 1);
    step();
    chk("t1_idle", busy, 0);
    chk("t1_idle_pulsos", cnt_pulsos, 0);
    // fresh reset, then all four requesters compete
    rst = 0;
    step();
    rst = 1;
    req_valid = 4'b1111;
    req_pulsos = 16'h4132;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ready", req_ready, 4'b0001 << i);
      step();
      req_valid[i] = 0;
      #1 chk("rr_ini", cnt_iniciar, 1);
      chk("rr_pulsos", cnt_pulsos, pv[i]);
      chk("rr_gid", grant_id, i);
      chk("rr_launch_ready", req_ready, 0);
      step();
      chk("rr_busy_ini", cnt_iniciar, 0);
      chk("rr_busy_ready", req_ready, 0);
      cnt_pronto = 1;
      step();
      chk("rr_done", done, 4'b0001 << i);
      cnt_pronto = 0;
      step();
      chk("rr_rel_ready", req_ready, 0);
      chk("rr_rel_ini", cnt_iniciar, 0);
      step();
    end
    // requester 2 holds valid, requester 0 arrives mid-job
    req_valid = 4'b0100;
    req_pulsos = 16'h0100;
    #1 chk("ns_ready2", req_ready, 4'b0100);
    step();
    req_valid = 4'b0101;
    req_pulsos = 16'h0102;
    #1 chk("ns_launch_ready", req_ready, 0);
    step();
    cnt_pronto = 1;
    #1 chk("ns_busy_ready", req_ready, 0);
    step();
    chk("ns_done2", done, 4'b0100);
    cnt_pronto = 0;
    step();
    step();
    chk("ns_ready0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0100;
    #1 chk("ns_gid0", grant_id, 0);
    chk("ns_pulsos0", cnt_pulsos, 2);
    step();
    cnt_pronto = 1;
    step();
    chk("ns_done0", done, 4'b0001);
    cnt_pronto = 0;
    step();
    step();
    chk("ns_ready2b", req_ready, 4'b0100);
    req_valid = 0;
    #1 chk("ns_withdraw", req_ready, 0);
    step();
    chk("ns_idle", busy, 0);
    // zero-pulse job on requester 3
    req_valid = 4'b1000;
    req_pulsos = 16'h0000;
    #1 chk("z_ready", req_ready, 4'b1000);
    step();
    req_valid = 0;
    #1 chk("z_done", done, 4'b1000);
    chk("z_ini", cnt_iniciar, 0);
    step();
    chk("z_idle", busy, 0);
    chk("z_ini2", cnt_iniciar, 0);
    // no grant while pronto is high, then a job that times out
    cnt_pronto = 1;
    req_valid = 4'b0001;
    req_pulsos = 16'h0001;
    #1 chk("p_block", req_ready, 0);
    cnt_pronto = 0;
    #1 chk("p_unblock", req_ready, 4'b0001);
    step();
    req_valid = 0;
    #1 chk("to_ini", cnt_iniciar, 1);
    step();
    for (int j = 1; j <= 20; j++) begin
      chk("to_noerr", err, 0);
      chk("to_nodone", done, 0);
      step();
    end
    chk("to_err", err, 4'b0001);
    chk("to_done", done, 0);
    step();
    chk("to_err_off", err, 0);
    step();
    chk("to_idle", busy, 0);
    // pronto arrives exactly at the timeout limit: completion wins
    req_valid = 4'b0010;
    req_pulsos = 16'h0050;
    #1 chk("tie_ready", req_ready, 4'b0010);
    step();
    req_valid = 0;
    step();
    for (int j = 1; j < 20; j++) step();
    cnt_pronto = 1;
    step();
    chk("tie_done", done, 4'b0010);
    chk("tie_err", err, 0);
    cnt_pronto = 0;
    step();
    step();
    chk("tie_idle", busy, 0);
    // async reset during BUSY
    req_valid = 4'b0010;
    req_pulsos = 16'h0020;
    step();
    req_valid = 0;
    step();
    chk("ar_busy_pre", busy, 1);
    rst = 0;
    #1 chk("ar_busy", busy, 0);
    chk("ar_pulsos", cnt_pulsos, 0);
    chk("ar_gid", grant_id, 0);
    step();
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    rst = 1;
    req_valid = 4'b0011;
    req_pulsos = 16'h0022;
    #1 chk("ar_ready0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    #1 chk("ar_pulsos2", cnt_pulsos, 2);
    chk("ar_ini", cnt_iniciar, 1);
    step();
    step();
    cnt_pronto = 1;
    step();
    chk("ar_done0", done, 4'b0001);
    cnt_pronto = 0;
    step();
    step();
    chk("ar_ready1", req_ready, 4'b0010);
    req_valid = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
